capture_buffer: RTL
===================

CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 Parameter WIDTH, default 4, sets the sample width in bits.
REQ-002 Parameter DEPTH, default 16, sets the buffer entries; it SHALL be a power of two, 4..256.
REQ-003 Parameter POST, default 8, sets the post-trigger samples written after the trigger sample; legal range 1..DEPTH-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 arm  input  1  one-cycle pulse; starts or restarts a capture.
REQ-007 trig  input  1  trigger from the pattern detector's detected output.
REQ-008 sample  input  WIDTH  raw probe sample, written once per cycle while capturing.
REQ-009 rd_req  input  1  readout request; one word per asserted cycle.
REQ-010 rd_data  output  WIDTH  registered readout word.
REQ-011 rd_valid  output  1  rd_data is valid this cycle.
REQ-012 armed  output  1  high in ARMED and CAPTURE states.
REQ-013 done  output  1  high in DONE state.
REQ-014 count  output  $clog2(DEPTH)+1  words still unread in DONE, else 0.

Function
REQ-015 States SHALL be IDLE, ARMED, CAPTURE and DONE; the state, wr_ptr, rd_ptr, write total and post counter SHALL all be registers.
REQ-016 IDLE: no writes; arm -> ARMED with wr_ptr=0, write total=0.
REQ-017 ARMED: each cycle write sample to mem[wr_ptr], wr_ptr+1 mod DEPTH, write total saturating at DEPTH.
REQ-018 ARMED with trig=1: that cycle's sample SHALL be written (trigger sample), post counter loaded with POST, next state CAPTURE.
REQ-019 CAPTURE: write one sample per cycle, decrement post counter; the cycle writing the last post sample SHALL transition to DONE; trig ignored.
REQ-020 On DONE entry: count=write total (max DEPTH); rd_ptr=wr_ptr-count mod DEPTH, i.e. the oldest retained sample.
REQ-021 DONE with rd_req=1 and count>0: on the next cycle rd_data=mem[rd_ptr] and rd_valid=1; rd_ptr+1 mod DEPTH, count-1 (read latency 1 cycle).
REQ-022 rd_req with count=0, or in any state other than DONE, SHALL be ignored; rd_valid SHALL be 0 on the following cycle.
REQ-023 After the final word is issued (count reaches 0), state SHALL return to IDLE; done falls in the same cycle rd_valid is presented for that word.
REQ-024 arm in ARMED, CAPTURE or DONE SHALL restart: ARMED, wr_ptr=0, write total=0, any pending readout abandoned.
REQ-025 arm and trig in the same cycle: arm wins; trig is discarded.
REQ-026 Pointers SHALL wrap silently modulo DEPTH; older samples are overwritten in ARMED without error.
REQ-027 Memory contents SHALL NOT be reset; only state, pointers and counters reset.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, wr_ptr=0, rd_ptr=0, counters=0, rd_data=0, rd_valid=0, armed=0, done=0, count=0.
REQ-029 rst SHALL take priority over arm, trig and rd_req, including mid-capture and mid-readout.
REQ-030 After rst, a new capture SHALL require a fresh arm pulse.

Verification (DEPTH=16, POST=8, WIDTH=4, sample = cycle index k mod 16 after arm)
REQ-031 Long pre-trigger: arm, trig on the 20th armed sample (s19) -> 28 writes, done=1, count=16; 16 rd_req cycles return s12..s27 mod 16 in order, then IDLE.
REQ-032 Short pre-trigger: trig on s2 -> 11 writes, count=11; readout returns s0..s10; the 12th rd_req gives rd_valid=0.
REQ-033 Gapped readout: rd_req toggled 1,0,1,0 in DONE -> rd_valid pulses 1 cycle after each request; data order unbroken; count decrements only on accepted reads.
REQ-034 arm+trig in the same cycle while ARMED -> restart, no CAPTURE; a later trig on s4 gives count=13.
REQ-035 rst asserted during CAPTURE at post counter=3 -> next cycle all outputs 0, state IDLE; trig then ignored until arm.
REQ-036 rd_req in IDLE/ARMED, and trig in IDLE -> no state change, rd_valid=0.

Source files
------------

// File: rtl/capture_buffer.sv
// capture_buffer: trigger-centred sample capture buffer with pre/post-trigger history.
// Latency: one sample written per cycle while capturing; readout data one cycle after rd_req.
// Backpressure: none; rd_req outside DONE or with nothing left to read is dropped (rd_valid stays 0).
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   arm             one-cycle pulse that starts or restarts a capture
//   trig            trigger from the pattern detector (honoured only in ARMED)
//   sample          probe sample written every ARMED/CAPTURE cycle
//   rd_req          readout request, one word per asserted cycle in DONE
//   rd_data         registered readout word, rd_valid marks the cycle it is valid
//   armed, done     status: ARMED/CAPTURE and DONE respectively
//   count           words still unread while in DONE, else 0
module capture_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [WIDTH-1:0]         sample,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     armed,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] POST_C  = AW'(POST);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Sample storage is never reset; only control state is.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q,    state_d;
  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]    total_q,    total_d;
  logic [AW-1:0]    post_q,     post_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [WIDTH-1:0] rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             we;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    total_d    = total_q;
    post_d     = post_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;

    // arm restarts from any state and overrides a same-cycle trigger.
    if (arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      total_d  = '0;
      post_d   = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
          if (total_q != DEPTH_C) total_d = total_q + ONE_C;
          if (trig) begin
            post_d  = POST_C;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
          if (total_q != DEPTH_C) total_d = total_q + ONE_C;
          post_d   = post_q - ONE_A;
          if (post_q == ONE_A) begin
            // Last post-trigger write: the oldest retained sample sits
            // total entries behind the next write position.
            state_d  = S_DONE;
            count_d  = total_d;
            rd_ptr_d = wr_ptr_d - total_d[AW-1:0];
          end
        end
        S_DONE: begin
          if (rd_req && count_q != '0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + ONE_A;
            count_d    = count_q - ONE_C;
            // Leaving DONE on the same edge that presents the final word.
            if (count_q == ONE_C) state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      total_q    <= '0;
      post_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      total_q    <= total_d;
      post_q     <= post_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= sample;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign armed    = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  // count_q is held at zero outside DONE.
  assign count    = count_q;

endmodule
